mux_n_pipe: RTL and testbench

Parametrised, registered N-to-1 data selector with valid/ready handshake, replacing fixed-width combinational 2:1/3:1 selectors at pipeline-stage boundaries (forwarding and writeback paths). It selects one of CHANNELS packed input words, registers it together with its select code, and absorbs one cycle of downstream backpressure in a single-entry skid buffer. Full throughput of one word per cycle is sustained under backpressure. Illegal select codes produce zero data and raise a sticky error flag.

---
 rtl/mux_n_pipe.sv | 113 +++++++++++
 tb/tb_mux_n_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// Registered N-to-1 data selector with valid/ready handshake and a single-entry
// skid buffer; illegal select codes yield zero data and a sticky error flag.
module mux_n_pipe #(
    parameter int SIZE     = 32,
    parameter int CHANNELS = 3,
    parameter int SEL_W    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CHANNELS*SIZE-1:0] data_i,
    input  logic [SEL_W-1:0]         select_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     flush_i,
    output logic [SIZE-1:0]          data_o,
    output logic [SEL_W-1:0]         sel_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     err_o
);

    localparam int              NSLOT = 2 ** SEL_W;
    localparam logic [SEL_W:0]  CH_L  = (SEL_W + 1)'(CHANNELS);

    // Every select code maps to a slot; codes beyond CHANNELS read as zero.
    logic [SIZE-1:0] chan_s [NSLOT];

    for (genvar k = 0; k < NSLOT; k++) begin : g_chan
        if (k < CHANNELS) begin : g_live
            assign chan_s[k] = data_i[k*SIZE +: SIZE];
        end else begin : g_zero
            assign chan_s[k] = '0;
        end
    end

    logic [SIZE-1:0]  pick_s;
    logic             illegal_s;
    logic             accept_s;
    logic             transfer_s;

    logic [SIZE-1:0]  main_data_r, main_data_s;
    logic [SEL_W-1:0] main_sel_r,  main_sel_s;
    logic             main_valid_r, main_valid_s;
    logic [SIZE-1:0]  skid_data_r, skid_data_s;
    logic [SEL_W-1:0] skid_sel_r,  skid_sel_s;
    logic             skid_valid_r, skid_valid_s;
    logic             err_r, err_s;

    // The widened compare is constant-false when CHANNELS fills the select space.
    assign pick_s     = chan_s[select_i];
    assign illegal_s  = ({1'b0, select_i} >= CH_L);
    assign accept_s   = valid_i && !skid_valid_r;
    assign transfer_s = main_valid_r && ready_i;

    // Next-state for main and skid entries; flush wins over accept and refill.
    always_comb begin
        main_data_s  = main_data_r;
        main_sel_s   = main_sel_r;
        main_valid_s = main_valid_r;
        skid_data_s  = skid_data_r;
        skid_sel_s   = skid_sel_r;
        skid_valid_s = skid_valid_r;
        err_s        = err_r | (accept_s & illegal_s);
        if (flush_i) begin
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
        end else if (transfer_s && skid_valid_r) begin
            main_data_s  = skid_data_r;
            main_sel_s   = skid_sel_r;
            skid_valid_s = 1'b0;
        end else if (accept_s && (!main_valid_r || transfer_s)) begin
            main_data_s  = pick_s;
            main_sel_s   = select_i;
            main_valid_s = 1'b1;
        end else if (accept_s) begin
            skid_data_s  = pick_s;
            skid_sel_s   = select_i;
            skid_valid_s = 1'b1;
        end else if (transfer_s) begin
            main_valid_s = 1'b0;
        end else begin
            main_valid_s = main_valid_r;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_data_r  <= '0;
            main_sel_r   <= '0;
            main_valid_r <= 1'b0;
            skid_data_r  <= '0;
            skid_sel_r   <= '0;
            skid_valid_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            main_data_r  <= main_data_s;
            main_sel_r   <= main_sel_s;
            main_valid_r <= main_valid_s;
            skid_data_r  <= skid_data_s;
            skid_sel_r   <= skid_sel_s;
            skid_valid_r <= skid_valid_s;
            err_r        <= err_s;
        end
    end

    assign data_o  = main_data_r;
    assign sel_o   = main_sel_r;
    assign valid_o = main_valid_r;
    assign ready_o = !skid_valid_r;
    assign err_o   = err_r;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe (SIZE=8, CHANNELS=3, SEL_W=2): directed vectors
// followed by a random handshake phase against an occupancy/queue model.
module tb_mux_n_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [23:0] data_i = 24'h33_22_11;
    logic [1:0]  select_i = 2'd0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        flush_i = 1'b0;
    logic [7:0]  data_o;
    logic [1:0]  sel_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic [9:0] sb_q[$];
    int         m_cnt = 0;
    logic       m_err = 1'b0;

    logic       hold_r = 1'b0;
    logic [7:0] hold_data;
    logic [1:0] hold_sel;

    mux_n_pipe #(.SIZE(8), .CHANNELS(3), .SEL_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
        .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
        .data_o(data_o), .sel_o(sel_o), .valid_o(valid_o),
        .ready_i(ready_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_word(input logic [23:0] d, input logic [1:0] s);
        case (s)
            2'd0:    return d[7:0];
            2'd1:    return d[15:8];
            2'd2:    return d[23:16];
            default: return 8'h00;
        endcase
    endfunction

    // Reference model: occupancy count, expected-word queue, sticky error.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_cnt = 0;
            m_err = 1'b0;
            sb_q.delete();
        end else begin
            automatic logic acc  = valid_i && (m_cnt < 2);
            automatic logic xfer = (m_cnt > 0) && ready_i;
            if (acc && select_i == 2'd3) m_err = 1'b1;
            if (flush_i) begin
                m_cnt = 0;
                sb_q.delete();
            end else begin
                m_cnt = m_cnt + int'(acc) - int'(xfer);
                if (acc) sb_q.push_back({select_i, model_word(data_i, select_i)});
            end
        end
    end

    // Monitor: handshake flags, stall stability, and in-order output words.
    always @(negedge clk_i) begin
        if (rst_i) begin
            hold_r = 1'b0;
        end else begin
            chk("valid_o", 32'(valid_o), 32'(m_cnt > 0));
            chk("ready_o", 32'(ready_o), 32'(m_cnt < 2));
            chk("err_o", 32'(err_o), 32'(m_err));
            if (hold_r) begin
                chk("stall_data", 32'(data_o), 32'(hold_data));
                chk("stall_sel", 32'(sel_o), 32'(hold_sel));
            end
            if (valid_o === 1'b1 && ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 32'({sel_o, data_o}), 32'h3ff);
                end else begin
                    automatic logic [9:0] e = sb_q.pop_front();
                    chk("out_data", 32'(data_o), 32'(e[7:0]));
                    chk("out_sel", 32'(sel_o), 32'(e[9:8]));
                end
            end
            hold_r    = (valid_o === 1'b1) && !ready_i && !flush_i;
            hold_data = data_o;
            hold_sel  = sel_o;
        end
    end

    task automatic drive(input logic v, input logic [1:0] s, input logic r, input logic f);
        valid_i  = v;
        select_i = s;
        ready_i  = r;
        flush_i  = f;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;

        // Back-to-back selects 0,1,2 with downstream always ready.
        drive(1'b1, 2'd0, 1'b1, 1'b0);
        chk("first_data", 32'(data_o), 32'h11);
        drive(1'b1, 2'd1, 1'b1, 1'b0);
        chk("second_data", 32'(data_o), 32'h22);
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        chk("third_data", 32'(data_o), 32'h33);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);

        // Backpressure fills main and skid, then drains in order.
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        chk("stall_hold22", 32'(data_o), 32'h22);
        chk("stall_ready_low", 32'(ready_o), 32'd0);
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        chk("drain_33", 32'(data_o), 32'h33);
        chk("drain_ready_high", 32'(ready_o), 32'd1);
        drive(1'b0, 2'd0, 1'b1, 1'b0);

        // Illegal select: zero data, raw select code, sticky error.
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        chk("illegal_data", 32'(data_o), 32'h00);
        chk("illegal_sel", 32'(sel_o), 32'd3);
        chk("illegal_err", 32'(err_o), 32'd1);
        for (int i = 0; i < 10; i++) drive(1'b1, 2'(i % 3), 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b1);
        chk("err_sticky", 32'(err_o), 32'd1);

        // Flush with two buffered words and a pending select-0 word.
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 1'b0, 1'b1);
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_ready", 32'(ready_o), 32'd1);
        drive(1'b0, 2'd0, 1'b1, 1'b0);

        // Flush concurrent with a transfer and an accept: accepted word discarded.
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        drive(1'b1, 2'd0, 1'b1, 1'b1);
        chk("flush_xfer_valid", 32'(valid_o), 32'd0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-stall with two words buffered.
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        chk("mid_rst_data", 32'(data_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        valid_i = 1'b0;

        // Random handshake traffic.
        for (int i = 0; i < 10000; i++) begin
            data_i = 24'($urandom);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 1'b1, 1'b0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
